// File: rtl/frame_buffer_arbiter.sv
// Double-buffered ROWS x COLS 1-bit frame store sharing one single-port memory between refresh reads and frame writes.
// Optional FB_CLEAR_ON_SWAP_EN: zero the new back bank after every bank swap.
module frame_buffer_arbiter #(
  parameter int ROWS = 64,
  parameter int COLS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req,
  input  logic [$clog2(ROWS)-2:0]   rd_addr,
  output logic [COLS-1:0]           rd_row0,
  output logic [COLS-1:0]           rd_row1,
  output logic                      rd_valid,
  output logic                      rd_overrun,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(ROWS)-1:0]   wr_addr,
  input  logic [COLS-1:0]           wr_data,
  input  logic                      frame_done,
  output logic                      front_sel,
  output logic                      swap_pending
);

  localparam int AW = $clog2(ROWS);
  localparam int HW = AW - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWAP  = 3'd1;
  localparam logic [2:0] S_RD_LO = 3'd3;
  localparam logic [2:0] S_RD_HI = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;
  localparam logic [2:0] S_WRITE = 3'd6;
`ifdef FB_CLEAR_ON_SWAP_EN
  localparam logic [2:0] S_CLEAR = 3'd2;
  logic [AW-1:0]         clr_cnt;
`endif

  logic [2:0]      state;
  logic            rd_pend;
  logic [HW-1:0]   rd_addr_q;
  logic [AW-1:0]   wr_addr_q;
  logic [COLS-1:0] wr_data_q;

  logic [COLS-1:0] mem [2*ROWS];
  logic            mem_we;
  logic [AW:0]     mem_waddr;
  logic [COLS-1:0] mem_wdata;

  // IDLE looks at the incoming strobes directly so a fresh request costs no extra cycle.
  logic            pend_now;
  logic [HW-1:0]   addr_now;
  logic            swap_now;
  logic            wr_fire;

  assign pend_now = rd_pend | rd_req;
  assign addr_now = rd_pend ? rd_addr_q : rd_addr;
  assign swap_now = swap_pending | frame_done;
  assign wr_ready = !reset && (state == S_IDLE) && !rd_pend && !rd_req && !swap_pending;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_valid = (state == S_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      rd_pend      <= 1'b0;
      rd_overrun   <= 1'b0;
      rd_addr_q    <= '0;
      rd_row0      <= '0;
      rd_row1      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
`ifdef FB_CLEAR_ON_SWAP_EN
      clr_cnt      <= '0;
`endif
    end else begin
      if (rd_req && !rd_pend) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= rd_addr;
      end else if (rd_req) begin
        rd_overrun <= 1'b1;
      end
      if (frame_done) swap_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pend_now && (addr_now == '0) && swap_now) begin
            state <= S_SWAP;
          end else if (pend_now) begin
            state <= S_RD_LO;
          end else if (wr_fire) begin
            state     <= S_WRITE;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
          end
        end
        S_SWAP: begin
          front_sel    <= ~front_sel;
          swap_pending <= 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
          clr_cnt      <= '0;
          state        <= S_CLEAR;
`else
          state        <= S_RD_LO;
`endif
        end
`ifdef FB_CLEAR_ON_SWAP_EN
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(ROWS - 1)) state <= S_RD_LO;
        end
`endif
        S_RD_LO: begin
          rd_row0 <= mem[{front_sel, 1'b0, rd_addr_q}];
          state   <= S_RD_HI;
        end
        S_RD_HI: begin
          rd_row1 <= mem[{front_sel, 1'b1, rd_addr_q}];
          state   <= S_RESP;
        end
        S_RESP: begin
          rd_pend <= 1'b0;
          state   <= S_IDLE;
        end
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single write port: row writes and clears both target the back bank.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state == S_WRITE) begin
      mem_we    = 1'b1;
      mem_waddr = {~front_sel, wr_addr_q};
      mem_wdata = wr_data_q;
    end
`ifdef FB_CLEAR_ON_SWAP_EN
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = {~front_sel, clr_cnt};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
